// File: rtl/shiftreg_piso_ctrl_pkg.sv
// Shared types and constants for the PISO shift-register controller.
// Imported by the controller, its datapath and its bus interface users.
package shiftreg_piso_ctrl_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam logic IDLE_LVL = 1'b0;

  // Counter width for a count range of n, never below one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shiftreg_piso_ctrl_if.sv
// Word-source handshake plus serial-sink bundle of the PISO controller.
// The source drives master; the controller sits on slave.
interface shiftreg_piso_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             abort;
  logic             sout;
  logic             sout_en;
  logic             busy;
  logic             done;

  modport master (
    output in_valid, in_data, abort,
    input  in_ready, sout, sout_en, busy, done
  );

  modport slave (
    input  in_valid, in_data, abort,
    output in_ready, sout, sout_en, busy, done
  );
endinterface

// File: rtl/shiftreg_piso_ctrl_piso.sv
// Parallel-load, right-shifting datapath register (zero fill).
// q0 always presents the bit currently at the serial end.
module shiftreg_piso #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             q0
);

  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;

  always_comb begin
    shreg_d = shreg_q;
    if (load)
      shreg_d = din;
    else if (shift)
      shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) shreg_q <= '0;
    else     shreg_q <= shreg_d;
  end

  assign q0 = shreg_q[0];

endmodule

// File: rtl/shiftreg_piso_ctrl.sv
// Sequencer for a PISO shift register: accepts a word per handshake and
// streams it LSB-first, DIV cycles per bit, with done/abort control.
module shiftreg_piso_ctrl
  import shiftreg_piso_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  shiftreg_piso_ctrl_if.slave  bus
);

  localparam int BW = cnt_w(WIDTH);
  localparam int DW = cnt_w(DIV);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  state_e        state_q, state_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          done_q, done_d;

  logic accept;
  logic div_end;
  logic last_end;
  logic shift;
  logic q0;

  assign accept   = (state_q == IDLE) && bus.in_valid;
  assign div_end  = (div_cnt_q == DIV_LAST);
  assign last_end = div_end && (bit_cnt_q == BIT_LAST);
  assign shift    = (state_q == SHIFT) && div_end && !bus.abort;

  shiftreg_piso #(.WIDTH(WIDTH)) u_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .shift (shift),
    .din   (bus.in_data),
    .q0    (q0)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      done_q    <= done_d;
    end
  end

  // Abort outranks the final bit-period edge, so it also suppresses done.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    done_d    = 1'b0;
    unique case (1'b1)
      state_q == IDLE: begin
        if (accept) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
          div_cnt_d = '0;
        end
      end
      state_q == SHIFT: begin
        if (bus.abort) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          div_cnt_d = '0;
        end else if (last_end) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          div_cnt_d = '0;
          done_d    = 1'b1;
        end else if (div_end) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          div_cnt_d = '0;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = (state_q == IDLE);
    bus.busy     = (state_q == SHIFT);
    bus.sout_en  = (state_q == SHIFT);
    bus.sout     = (state_q == SHIFT) ? q0 : IDLE_LVL;
    bus.done     = done_q;
  end

endmodule

// File: tb/tb_shiftreg_piso_ctrl.sv
// Directed bench for shiftreg_piso_ctrl with a timeline model of each word.
// Two instances: WIDTH=8/DIV=1 (b1) and WIDTH=8/DIV=3 (b3).
module tb_shiftreg_piso_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errs = 0;
  int   checks = 0;
  int   cyc = 0;

  shiftreg_piso_ctrl_if #(.WIDTH(8)) b1 ();
  shiftreg_piso_ctrl_if #(.WIDTH(8)) b3 ();

  shiftreg_piso_ctrl #(.WIDTH(8), .DIV(1)) dut1 (
    .clk (clk), .rst (rst), .bus (b1.slave)
  );
  shiftreg_piso_ctrl #(.WIDTH(8), .DIV(3)) dut3 (
    .clk (clk), .rst (rst), .bus (b3.slave)
  );

  always #5 clk = ~clk;

  // Word timeline: active over cycles st..en, done expected in cycle dc.
  typedef struct {
    bit         act;
    int         st;
    int         en;
    logic [7:0] w;
    int         dc;
  } mdl_t;

  mdl_t m[2];
  int   dv[2] = '{1, 3};

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, a, e, $time);
    end
  endtask

  function automatic void step(input int i, input logic v,
                               input logic [7:0] d, input logic ab,
                               input int c);
    if (m[i].act) begin
      if (ab) m[i].act = 1'b0;
      else if (c == m[i].en) begin
        m[i].act = 1'b0;
        m[i].dc  = c + 1;
      end
    end else if (v) begin
      m[i].act = 1'b1;
      m[i].st  = c + 1;
      m[i].en  = c + 8 * dv[i];
      m[i].w   = d;
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m[i].act = 1'b0;
        m[i].dc  = -1;
      end
    end else begin
      step(0, b1.in_valid, b1.in_data, b1.abort, cyc);
      step(1, b3.in_valid, b3.in_data, b3.abort, cyc);
      cyc = cyc + 1;
    end
  end

  function automatic logic exp_sout(input int i);
    if (!m[i].act) return 1'b0;
    return m[i].w[(cyc - m[i].st) / dv[i]];
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      chk("m1_busy",  b1.busy,     m[0].act);
      chk("m1_en",    b1.sout_en,  m[0].act);
      chk("m1_rdy",   b1.in_ready, !m[0].act);
      chk("m1_sout",  b1.sout,     exp_sout(0));
      chk("m1_done",  b1.done,     cyc == m[0].dc);
      chk("m3_busy",  b3.busy,     m[1].act);
      chk("m3_en",    b3.sout_en,  m[1].act);
      chk("m3_rdy",   b3.in_ready, !m[1].act);
      chk("m3_sout",  b3.sout,     exp_sout(1));
      chk("m3_done",  b3.done,     cyc == m[1].dc);
    end
  end

  task automatic send1(input logic [7:0] d, input logic ab);
    @(negedge clk); #1;
    b1.in_valid = 1'b1; b1.in_data = d; b1.abort = ab;
    @(posedge clk); #1;
    b1.in_valid = 1'b0; b1.abort = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  bit a5[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  int nd;

  initial begin
    b1.in_valid = 0; b1.in_data = '0; b1.abort = 0;
    b3.in_valid = 0; b3.in_data = '0; b3.abort = 0;
    #3;
    chk("rst_sout", b1.sout, 0);
    chk("rst_en",   b1.sout_en, 0);
    chk("rst_busy", b1.busy, 0);
    chk("rst_done", b1.done, 0);
    @(negedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_rdy1", b1.in_ready, 1);
    chk("rst_rdy3", b3.in_ready, 1);

    // 8'hA5, DIV=1
    send1(8'hA5, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk($sformatf("a5_bit%0d", i - 1), b1.sout, a5[i-1]);
      chk("a5_en", b1.sout_en, 1);
    end
    @(negedge clk);
    chk("a5_done", b1.done, 1);
    chk("a5_rdy",  b1.in_ready, 1);
    chk("a5_busy", b1.busy, 0);
    @(negedge clk);
    chk("a5_done_off", b1.done, 0);

    // 8'h01, DIV=3
    @(negedge clk); #1;
    b3.in_valid = 1'b1; b3.in_data = 8'h01;
    @(posedge clk); #1 b3.in_valid = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      chk($sformatf("d3_sout_c%0d", c), b3.sout, c <= 3);
      chk("d3_nodone", b3.done, 0);
    end
    @(negedge clk);
    chk("d3_done", b3.done, 1);
    idle(2);

    // Back-to-back FF then 00 with in_valid held
    @(negedge clk); #1;
    b1.in_valid = 1'b1; b1.in_data = 8'hFF;
    @(posedge clk); #1 b1.in_data = 8'h00;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk("b2b_ff", b1.sout, 1);
    end
    @(negedge clk);
    chk("b2b_gap_done", b1.done, 1);
    chk("b2b_gap_sout", b1.sout, 0);
    chk("b2b_gap_rdy",  b1.in_ready, 1);
    @(posedge clk); #1 b1.in_valid = 1'b0;
    for (int c = 10; c <= 17; c++) begin
      @(negedge clk);
      chk("b2b_00_en",   b1.sout_en, 1);
      chk("b2b_00_sout", b1.sout, 0);
    end
    @(negedge clk);
    chk("b2b_done2", b1.done, 1);
    idle(2);

    // in_valid pulsed while busy
    send1(8'h3C, 1'b0);
    nd = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (b1.done) nd++;
      if (c == 4) begin
        #1 b1.in_valid = 1'b1; b1.in_data = 8'hAA;
      end else if (c == 5) begin
        #1 b1.in_valid = 1'b0;
      end
    end
    chk("pulse_done_cnt", nd, 1);
    chk("pulse_idle", b1.busy, 0);

    // abort in cycle 4 of 8'hFF
    send1(8'hFF, 1'b0);
    idle(3);
    @(negedge clk); #1 b1.abort = 1'b1;
    @(negedge clk);
    chk("ab_en",  b1.sout_en, 0);
    chk("ab_rdy", b1.in_ready, 1);
    #1 b1.abort = 1'b0;
    nd = 0;
    for (int c = 6; c <= 10; c++) begin
      @(negedge clk);
      if (b1.done) nd++;
    end
    chk("ab_nodone", nd, 0);

    // abort held high during an IDLE handshake does not block it
    send1(8'h81, 1'b1);
    @(negedge clk);
    chk("ab_idle_acc", b1.busy, 1);
    chk("ab_idle_b0",  b1.sout, 1);
    idle(7);
    chk("ab_idle_b7",  b1.sout, 1);
    @(negedge clk);
    chk("ab_idle_done", b1.done, 1);

    // abort on the final bit-period edge beats done
    send1(8'hC3, 1'b0);
    idle(7);
    @(negedge clk); #1 b1.abort = 1'b1;
    @(negedge clk);
    chk("ab_last_done", b1.done, 0);
    chk("ab_last_rdy",  b1.in_ready, 1);
    #1 b1.abort = 1'b0;
    idle(2);

    // async reset in cycle 5 of a word
    send1(8'hFF, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("ar_sout", b1.sout, 0);
    chk("ar_en",   b1.sout_en, 0);
    chk("ar_busy", b1.busy, 0);
    chk("ar_done", b1.done, 0);
    @(negedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("ar_rdy", b1.in_ready, 1);
    nd = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (b1.done) nd++;
    end
    chk("ar_nodone", nd, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
